// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: word width,
// reset/increment constants and the fetch FSM state encoding.
package if_fetch_unit_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [WORD_W-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [WORD_W-1:0] PC_INC   = 32'h0000_0004;

    // REQ   : request outstanding at addr_q, waiting for imem_ready
    // HOLD  : word captured under freeze, replayed from hold_q
    // DRAIN : redirected while a request was in flight; swallow its response
    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

endpackage : if_fetch_unit_pkg

// File: rtl/if_fetch_unit_pc_adder.sv
// Word-address incrementer; wraps modulo 2^32 by construction.
module pc_adder
    import if_fetch_unit_pkg::*;
(
    input  logic [WORD_W-1:0] addr_i,
    output logic [WORD_W-1:0] sum_o
);

    assign sum_o = addr_i + PC_INC;

endmodule : pc_adder

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: issues requests to instruction memory, hands
// fetched words to the IF/ID register, buffers a word across a freeze and
// discards in-flight responses after a branch redirect.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              Branch_taken,
    input  logic [WORD_W-1:0] Branch_Address,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic [WORD_W-1:0] PC,
    output logic [WORD_W-1:0] Instruction,
    output logic              out_valid
);

    fetch_state_t      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic              start_q;
    logic [WORD_W-1:0] addr_plus4;

    // One incrementer serves both the delivered PC and the sequential advance.
    pc_adder u_pc_adder (
        .addr_i (addr_q),
        .sum_o  (addr_plus4)
    );

    // Memory-side and IF/ID-side outputs; nothing is issued or delivered
    // while in reset or in the first cycle after reset release.
    always_comb begin
        imem_req    = 1'b0;
        imem_addr   = addr_q;
        out_valid   = 1'b0;
        PC          = '0;
        Instruction = '0;
        if (rst && !start_q) begin
            unique case (state_q)
                ST_REQ: begin
                    imem_req  = 1'b1;
                    out_valid = imem_ready && !Branch_taken;
                    if (out_valid) begin
                        PC          = addr_plus4;
                        Instruction = imem_rdata;
                    end
                end
                ST_HOLD: begin
                    out_valid = !Branch_taken;
                    if (out_valid) begin
                        PC          = addr_plus4;
                        Instruction = hold_q;
                    end
                end
                ST_DRAIN: begin
                    imem_req = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic; a branch outranks freeze and imem_ready everywhere.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        hold_d  = hold_q;
        if (start_q) begin
            if (Branch_taken) begin
                pc_d   = Branch_Address;
                addr_d = Branch_Address;
            end
        end else begin
            unique case (state_q)
                ST_REQ: begin
                    if (Branch_taken) begin
                        pc_d = Branch_Address;
                        if (imem_ready) begin
                            addr_d = Branch_Address;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end else if (imem_ready) begin
                        if (freeze) begin
                            hold_d  = imem_rdata;
                            state_d = ST_HOLD;
                        end else begin
                            pc_d   = addr_plus4;
                            addr_d = addr_plus4;
                        end
                    end
                end
                ST_HOLD: begin
                    if (Branch_taken) begin
                        pc_d    = Branch_Address;
                        addr_d  = Branch_Address;
                        state_d = ST_REQ;
                    end else if (!freeze) begin
                        pc_d    = addr_plus4;
                        addr_d  = addr_plus4;
                        state_d = ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (Branch_taken) begin
                        pc_d = Branch_Address;
                    end
                    if (imem_ready) begin
                        addr_d  = Branch_Taken_or_pc(Branch_taken, Branch_Address, pc_q);
                        state_d = ST_REQ;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    // Picks the redirect target for the drain exit, honouring a late branch.
    function automatic logic [WORD_W-1:0] Branch_Taken_or_pc(
        input logic              taken,
        input logic [WORD_W-1:0] target,
        input logic [WORD_W-1:0] cur_pc
    );
        return taken ? target : cur_pc;
    endfunction

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            hold_q  <= '0;
            start_q <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            hold_q  <= hold_d;
            start_q <= 1'b0;
        end
    end

endmodule : if_fetch_unit
